// File: rtl/uart_tx_word.sv
// uart_tx_word: serialises a captured 32-bit word as four UART byte frames,
// least-significant byte first, each frame 8N1 (start, 8 data bits LSB first,
// stop). Reports tx_busy for the whole word and a one-cycle tx_done pulse.
//
// Optional build macro: UART_TX_PARITY_EN
//   defined   -> an even-parity bit follows data bit 7 in every frame (8E1)
//   undefined -> plain 8N1 framing
//
// All outputs are registered; reset (PRESET) is synchronous and active-high.
module uart_tx_word #(
    parameter int CLKS_PER_BIT = 16,
    parameter int CNT_W        = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        start,
    input  logic [31:0] To_TX,
    output logic        tx,
    output logic        tx_busy,
    output logic        tx_done
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd4;
`ifdef UART_TX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif

    // Last value of the baud counter within one bit period.
    localparam logic [CNT_W-1:0] BIT_TERM = CNT_W'(CLKS_PER_BIT - 1);

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit_idx;
    logic [1:0]       r_byte_idx;
    logic [31:0]      r_shift;
    logic             r_tx;
    logic             r_busy;
    logic             r_done;

    logic             w_bit_end;
    logic [7:0]       w_cur_byte;
    logic [2:0]       w_next_bit;

    // The byte in flight always sits in the low 8 bits; the word is shifted
    // down by one byte after every stop bit.
    assign w_bit_end  = (r_cnt == BIT_TERM);
    assign w_cur_byte = r_shift[7:0];
    assign w_next_bit = r_bit_idx + 3'd1;

    assign tx      = r_tx;
    assign tx_busy = r_busy;
    assign tx_done = r_done;

    // Frame sequencer: every state holds its line level for one full bit time
    // and presents the next bit on the register edge that ends the bit.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_bit_idx  <= 3'd0;
            r_byte_idx <= 2'd0;
            r_shift    <= 32'd0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx   <= 1'b1;
                    r_busy <= 1'b0;
                    if (start) begin
                        r_shift    <= To_TX;
                        r_byte_idx <= 2'd0;
                        r_bit_idx  <= 3'd0;
                        r_cnt      <= '0;
                        r_tx       <= 1'b0;
                        r_busy     <= 1'b1;
                        r_state    <= S_START;
                    end
                end
                S_START: begin
                    if (w_bit_end) begin
                        r_cnt     <= '0;
                        r_bit_idx <= 3'd0;
                        r_tx      <= w_cur_byte[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            r_tx    <= ^w_cur_byte;
                            r_state <= S_PARITY;
`else
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
`endif
                        end else begin
                            r_bit_idx <= w_next_bit;
                            r_tx      <= w_cur_byte[w_next_bit];
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_cnt   <= '0;
                        r_tx    <= 1'b1;
                        r_state <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
`endif
                S_STOP: begin
                    if (w_bit_end) begin
                        r_cnt <= '0;
                        if (r_byte_idx == 2'd3) begin
                            r_tx    <= 1'b1;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            // Next frame starts immediately, no idle gap.
                            r_byte_idx <= r_byte_idx + 2'd1;
                            r_shift    <= {8'h00, r_shift[31:8]};
                            r_tx       <= 1'b0;
                            r_state    <= S_START;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_word.sv
// Testbench for uart_tx_word. Stimulus pushes expected bytes and expected
// completion times into queues; independent monitors (a UART line receiver,
// a tx_done watcher and a busy/idle-line watcher) pop and compare.
module tb_uart_tx_word;

    localparam int C = 4;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 11;
`else
    localparam int FRAME = 10;
`endif
    localparam int WORD = 4 * FRAME * C;

    logic        clk = 1'b0;
    logic        PRESET = 1'b1;
    logic        start = 1'b0;
    logic [31:0] To_TX = 32'd0;
    logic        tx;
    logic        tx_busy;
    logic        tx_done;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // Reference model state: bytes still to appear on the line, edges at
    // which accepted words were captured, and the edge of the word in flight.
    logic [7:0] exp_byte[$];
    int         exp_done[$];
    int         cur_accept = -1;
    bit         rx_hold = 1'b1;

    uart_tx_word #(.CLKS_PER_BIT(C), .CNT_W(16)) dut (
        .PCLK    (clk),
        .PRESET  (PRESET),
        .start   (start),
        .To_TX   (To_TX),
        .tx      (tx),
        .tx_busy (tx_busy),
        .tx_done (tx_done)
    );

    always #5 clk = ~clk;

    // Counts rising edges; after edge k (and until edge k+1) cyc == k.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got=%h expected=%h", name, cyc, got, exp);
        end
    endtask

    // Busy must be high exactly in the cycles after capture edge A up to and
    // including the cycle of edge A+WORD-1; the line must idle high otherwise.
    always @(negedge clk) begin
        if (PRESET === 1'b0) begin
            bit eb;
            eb = (cur_accept >= 0) && (cyc >= cur_accept) && (cyc < cur_accept + WORD);
            check("busy", {31'd0, tx_busy}, {31'd0, eb});
            if (!eb) check("idle_tx", {31'd0, tx}, 32'd1);
        end
    end

    // tx_done is registered on edge A+WORD (visible until edge A+WORD+1).
    always @(negedge clk) begin
        if (tx_done === 1'b1) begin
            if (exp_done.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_done at cycle %0d: got=1 expected=0", cyc);
            end else begin
                int a;
                a = exp_done.pop_front();
                check("done_latency", 32'(cyc - a), 32'(WORD));
                check("done_busy_low", {31'd0, tx_busy}, 32'd0);
            end
        end
    end

    // Line receiver: samples every cycle of a frame, requires each bit to be
    // stable for C cycles, then compares the frame with the next expected byte.
    initial begin
        int         rc;
        bit         act;
        bit         gl;
        bit         ok;
        logic       rb[0:10];
        logic [7:0] d;
        logic [7:0] e;
        act = 1'b0;
        rc  = 0;
        gl  = 1'b0;
        forever begin
            @(negedge clk);
            if (rx_hold) begin
                act = 1'b0;
            end else if (!act) begin
                if (tx === 1'b0) begin
                    act   = 1'b1;
                    rc    = 0;
                    gl    = 1'b0;
                    rb[0] = tx;
                end
            end else begin
                rc++;
                if (rc % C == 0) rb[rc / C] = tx;
                else if (tx !== rb[rc / C]) gl = 1'b1;
                if (rc == FRAME * C - 1) begin
                    act = 1'b0;
                    for (int b = 0; b < 8; b++) d[b] = rb[1 + b];
                    checks++;
                    if (exp_byte.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_frame at cycle %0d: got=%h expected=none", cyc, d);
                    end else begin
                        e  = exp_byte.pop_front();
                        ok = (d === e) && (rb[0] === 1'b0) && (rb[FRAME-1] === 1'b1) && !gl;
`ifdef UART_TX_PARITY_EN
                        ok = ok && (rb[9] === ^e);
`endif
                        if (!ok) begin
                            failures++;
                            $display("FAIL frame at cycle %0d: got data=%h start=%b stop=%b unstable=%b expected data=%h start=0 stop=1 unstable=0",
                                     cyc, d, rb[0], rb[FRAME-1], gl, e);
                        end
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive start for one cycle; the model accepts it only when no word is
    // in flight (the tx_done cycle counts as idle).
    task automatic issue(input logic [31:0] w);
        int e;
        e     = cyc + 1;
        start = 1'b1;
        To_TX = w;
        if (cur_accept < 0 || e >= cur_accept + WORD + 1) begin
            cur_accept = e;
            for (int k = 0; k < 4; k++) exp_byte.push_back(w[8*k +: 8]);
            exp_done.push_back(e);
        end
        tick();
        start = 1'b0;
        To_TX = $urandom;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        if (cur_accept >= 0 && cyc <= cur_accept + WORD) begin
            while (tx_done !== 1'b1 && n < 2 * WORD) begin
                tick();
                n++;
            end
            if (tx_done !== 1'b1) begin
                checks++;
                failures++;
                $display("FAIL %s_timeout at cycle %0d: got tx_done=0 expected=1", name, cyc);
            end
        end
    endtask

    initial begin
        int a;
        int g;
        repeat (3) tick();
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_busy", {31'd0, tx_busy}, 32'd0);
        check("reset_done", {31'd0, tx_done}, 32'd0);
        PRESET  = 1'b0;
        rx_hold = 1'b0;
        repeat (2) tick();

        // Basic word with a start pulse while busy that must be ignored.
        issue(32'hA55A0F31);
        a = cur_accept;
        while (cyc < a + 49) tick();
        issue(32'hFFFFFFFF);
        wait_done("basic");

        // Back-to-back: start in the tx_done cycle.
        issue(32'h00000000);
        check("b2b_start_bit", {31'd0, tx}, 32'd0);
        check("b2b_busy", {31'd0, tx_busy}, 32'd1);
        wait_done("b2b");
        repeat (3) tick();

        // Reset in the middle of a frame.
        issue(32'h12345678);
        a = cur_accept;
        while (cyc < a + 69) tick();
        PRESET     = 1'b1;
        rx_hold    = 1'b1;
        cur_accept = -1;
        exp_byte.delete();
        exp_done.delete();
        tick();
        PRESET  = 1'b0;
        rx_hold = 1'b0;
        check("midreset_tx", {31'd0, tx}, 32'd1);
        check("midreset_busy", {31'd0, tx_busy}, 32'd0);
        repeat (10) tick();

        issue(32'h000000FF);
        wait_done("after_reset");
        repeat (2) tick();
        issue(32'h00000103);
        wait_done("parity_word");

        // Random words with random gaps, some inside busy, some in tx_done.
        for (int i = 0; i < 8; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                wait_done("rand_b2b");
            end else begin
                g = $urandom_range(0, WORD + 8);
                repeat (g) tick();
            end
            issue($urandom);
        end
        wait_done("drain");
        repeat (4) tick();
        check("bytes_left", 32'(exp_byte.size()), 32'd0);
        check("dones_left", 32'(exp_done.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
